// File: rtl/fcs_checker.sv
// rtl/fcs_checker.sv - receive-side Ethernet FCS (CRC-32) checker and stripper
//
// Purpose: takes a 16-bit word stream whose final two words carry the FCS,
// forwards the payload with the FCS removed and issues one status record per
// frame (FCS ok, runt, giant, byte length).
//
// Optional feature macro: FCS_STATS_EN enables the good_cnt/bad_cnt frame
// counters; without it both ports are tied to zero.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   s_data     input word, s_data[7:0] is the earlier byte on the wire
//   s_valid    input word valid (no backpressure)
//   s_last     final word of the frame (FCS[31:16])
//   m_data     payload word, FCS stripped
//   m_valid    payload word strobe
//   m_last     last payload word of the frame
//   st_valid   one-cycle status strobe
//   st_fcs_ok  CRC residue matched
//   st_runt    frame word count < MIN_WORDS
//   st_giant   frame word count > MAX_WORDS
//   st_len     frame length in bytes, FCS included, saturating
//   good_cnt   good frame count (FCS_STATS_EN)
//   bad_cnt    bad frame count (FCS_STATS_EN)

module fcs_checker #(
    parameter int MIN_WORDS = 32,
    parameter int MAX_WORDS = 759
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic [15:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        st_valid,
    output logic        st_fcs_ok,
    output logic        st_runt,
    output logic        st_giant,
    output logic [15:0] st_len,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
);

    localparam logic [15:0] MIN_W   = 16'(MIN_WORDS);
    localparam logic [15:0] MAX_W   = 16'(MAX_WORDS);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;

    typedef enum logic [1:0] {IDLE, DATA, REPORT} state_t;

    state_t      state;
    logic [31:0] crc;
    logic [15:0] word_cnt;
    logic [15:0] p0;
    logic [15:0] p1;
    logic        p0_full;
    logic        p1_full;

    function automatic logic [31:0] crc_fold_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Any word arriving outside DATA (IDLE or the REPORT cycle) opens a frame.
    logic        frame_start;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [15:0] cnt_next;
    logic [15:0] len_next;
    logic        fcs_ok_next;
    logic        runt_next;
    logic        giant_next;

    always_comb begin
        frame_start = (state != DATA);
        crc_base    = frame_start ? CRC_INIT : crc;
        crc_next    = crc_fold_byte(crc_fold_byte(crc_base, s_data[7:0]), s_data[15:8]);
        if (frame_start)
            cnt_next = 16'd1;
        else if (word_cnt == 16'hFFFF)
            cnt_next = word_cnt;
        else
            cnt_next = word_cnt + 16'd1;
        // 2 x count overflows 16 bits once bit 15 is set.
        len_next    = cnt_next[15] ? 16'hFFFF : {cnt_next[14:0], 1'b0};
        fcs_ok_next = (crc_next == RESIDUE);
        runt_next   = (cnt_next < MIN_W);
        giant_next  = (cnt_next > MAX_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            crc       <= CRC_INIT;
            word_cnt  <= '0;
            p0        <= '0;
            p1        <= '0;
            p0_full   <= 1'b0;
            p1_full   <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            st_valid  <= 1'b0;
            st_fcs_ok <= 1'b0;
            st_runt   <= 1'b0;
            st_giant  <= 1'b0;
            st_len    <= '0;
        end else begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            st_valid <= 1'b0;
            if (s_valid) begin
                word_cnt <= cnt_next;
                // The oldest held word leaves once two newer words are behind it;
                // on the s_last word it is the final payload word.
                if (!frame_start && p1_full) begin
                    m_data  <= p1;
                    m_valid <= 1'b1;
                    m_last  <= s_last;
                end
                if (s_last) begin
                    state     <= REPORT;
                    crc       <= CRC_INIT;
                    st_valid  <= 1'b1;
                    st_fcs_ok <= fcs_ok_next;
                    st_runt   <= runt_next;
                    st_giant  <= giant_next;
                    st_len    <= len_next;
                    // FCS[15:0] in p0 and the s_last word are discarded.
                    p0_full   <= 1'b0;
                    p1_full   <= 1'b0;
                end else begin
                    state <= DATA;
                    crc   <= crc_next;
                    p0    <= s_data;
                    if (frame_start) begin
                        p0_full <= 1'b1;
                        p1_full <= 1'b0;
                    end else begin
                        p1      <= p0;
                        p1_full <= p0_full;
                        p0_full <= 1'b1;
                    end
                end
            end else if (state == REPORT) begin
                state <= IDLE;
            end
        end
    end

`ifdef FCS_STATS_EN
    logic [31:0] good_q;
    logic [31:0] bad_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (s_valid && s_last) begin
            // Counted on the same edge that raises st_valid.
            if (fcs_ok_next && !runt_next && !giant_next)
                good_q <= good_q + 32'd1;
            else
                bad_q <= bad_q + 32'd1;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_fcs_checker.sv
// tb/tb_fcs_checker.sv - directed self-checking bench for fcs_checker

module tb_fcs_checker;

`ifdef FCS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        st_valid;
    logic        st_fcs_ok;
    logic        st_runt;
    logic        st_giant;
    logic [15:0] st_len;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    fcs_checker #(.MIN_WORDS(32), .MAX_WORDS(759)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .st_valid(st_valid), .st_fcs_ok(st_fcs_ok), .st_runt(st_runt),
        .st_giant(st_giant), .st_len(st_len),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    logic [16:0] tx_q[$];   // {last, data} words to drive
    logic [16:0] exp_q[$];  // {m_last, m_data} expected payload
    logic [16:0] out_q[$];  // captured payload
    logic [19:0] st_q[$];   // captured {m_last_same_cycle, ok, runt, giant, len}

    always @(negedge clk) begin
        if (m_valid) out_q.push_back({m_last, m_data});
        if (st_valid) st_q.push_back({m_valid & m_last, st_fcs_ok, st_runt, st_giant, st_len});
    end

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [15:0] w);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 2; k++) begin
            r = r ^ {24'h0, (k == 0) ? w[7:0] : w[15:8]};
            for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Appends n payload words base..base+n-1 plus zlib-style FCS to tx_q.
    task automatic build_frame(input int n, input logic [15:0] base, input bit corrupt);
        logic [31:0] c;
        logic [15:0] w;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            w = base + 16'(i);
            c = crc_word(c, w);
            tx_q.push_back({1'b0, w});
            exp_q.push_back({(i == n - 1), w});
        end
        c = ~c;
        if (corrupt) c = c ^ 32'h1;
        tx_q.push_back({1'b0, c[15:0]});
        tx_q.push_back({1'b1, c[31:16]});
    endtask

    task automatic send_tx();
        while (tx_q.size() > 0) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = tx_q[0][15:0];
            s_last  = tx_q[0][16];
            void'(tx_q.pop_front());
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_capture();
        out_q.delete();
        st_q.delete();
        exp_q.delete();
    endtask

    function automatic int first_out_mismatch();
        int n;
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        total++; if ({m_valid, m_last, st_valid} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {m_valid, m_last, st_valid}); else passed++;
        total++; if ({st_fcs_ok, st_runt, st_giant, st_len, m_data} !== 35'h0) $display("FAIL reset_fields got %h want 0", {st_fcs_ok, st_runt, st_giant, st_len, m_data}); else passed++;
        total++; if ({good_cnt, bad_cnt} !== 64'h0) $display("FAIL reset_counters got %h want 0", {good_cnt, bad_cnt}); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        logic [15:0] words[7];
        int idx;
        words = '{16'h3231, 16'h3433, 16'h3635, 16'h3837, 16'h3039, 16'hAEE5, 16'h261D};
        clear_capture();
        for (int i = 0; i < 7; i++) tx_q.push_back({(i == 6), words[i]});
        for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), words[i]});
        send_tx();
        exp_bad++;
        total++; if (st_q.size() !== 1) $display("FAIL kv_st_count got %0d want 1", st_q.size()); else passed++;
        if (st_q.size() > 0) begin
            total++; if (st_q[0] !== {1'b1, 1'b1, 1'b1, 1'b0, 16'd14}) $display("FAIL kv_status got %h want %h", st_q[0], {1'b1, 1'b1, 1'b1, 1'b0, 16'd14}); else passed++;
        end
        total++; if (out_q.size() !== 5) $display("FAIL kv_out_count got %0d want 5", out_q.size()); else passed++;
        idx = first_out_mismatch();
        total++; if (idx != -1) $display("FAIL kv_out_words at %0d got %h want %h", idx, out_q[idx], exp_q[idx]); else passed++;
        total++; if (st_len !== 16'd14 || st_fcs_ok !== 1'b1) $display("FAIL kv_hold got len=%0d ok=%b want len=14 ok=1", st_len, st_fcs_ok); else passed++;
        total++; if (good_cnt !== (STATS ? 32'(exp_good) : 32'd0) || bad_cnt !== (STATS ? 32'(exp_bad) : 32'd0))
            $display("FAIL kv_counters got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, STATS ? exp_good : 0, STATS ? exp_bad : 0); else passed++;
    endtask

    task automatic test_bad_fcs();
        logic [15:0] words[7];
        words = '{16'h3231, 16'h3433, 16'h3635, 16'h3837, 16'h3039, 16'hAEE5, 16'h261C};
        clear_capture();
        for (int i = 0; i < 7; i++) tx_q.push_back({(i == 6), words[i]});
        send_tx();
        exp_bad++;
        total++; if (st_q.size() !== 1) $display("FAIL bad_st_count got %0d want 1", st_q.size()); else passed++;
        if (st_q.size() > 0) begin
            total++; if (st_q[0][18:0] !== {1'b0, 1'b1, 1'b0, 16'd14}) $display("FAIL bad_status got %h want %h", st_q[0][18:0], {1'b0, 1'b1, 1'b0, 16'd14}); else passed++;
        end
        total++; if (good_cnt !== (STATS ? 32'(exp_good) : 32'd0) || bad_cnt !== (STATS ? 32'(exp_bad) : 32'd0))
            $display("FAIL bad_counters got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, STATS ? exp_good : 0, STATS ? exp_bad : 0); else passed++;
    endtask

    task automatic test_min_frame();
        int idx;
        // 62 bytes: one word short of the minimum.
        clear_capture();
        build_frame(29, 16'h0000, 1'b0);
        send_tx();
        exp_bad++;
        total++; if (st_q.size() !== 1 || st_q[0][18:0] !== {1'b1, 1'b1, 1'b0, 16'd62})
            $display("FAIL runt31_status got n=%0d %h want n=1 %h", st_q.size(), (st_q.size() > 0) ? st_q[0][18:0] : 19'h0, {1'b1, 1'b1, 1'b0, 16'd62}); else passed++;
        // Exactly 64 bytes.
        clear_capture();
        build_frame(30, 16'h0000, 1'b0);
        send_tx();
        exp_good++;
        total++; if (st_q.size() !== 1 || st_q[0][18:0] !== {1'b1, 1'b0, 1'b0, 16'd64})
            $display("FAIL min64_status got n=%0d %h want n=1 %h", st_q.size(), (st_q.size() > 0) ? st_q[0][18:0] : 19'h0, {1'b1, 1'b0, 1'b0, 16'd64}); else passed++;
        total++; if (out_q.size() !== 30) $display("FAIL min64_out_count got %0d want 30", out_q.size()); else passed++;
        idx = first_out_mismatch();
        total++; if (idx != -1) $display("FAIL min64_out_words at %0d got %h want %h", idx, out_q[idx], exp_q[idx]); else passed++;
        total++; if (good_cnt !== (STATS ? 32'(exp_good) : 32'd0) || bad_cnt !== (STATS ? 32'(exp_bad) : 32'd0))
            $display("FAIL min64_counters got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, STATS ? exp_good : 0, STATS ? exp_bad : 0); else passed++;
    endtask

    task automatic test_back_to_back();
        int idx;
        clear_capture();
        build_frame(32, 16'h0100, 1'b0);
        build_frame(34, 16'h0200, 1'b0);
        send_tx();
        exp_good += 2;
        total++; if (st_q.size() !== 2) $display("FAIL b2b_st_count got %0d want 2", st_q.size()); else passed++;
        if (st_q.size() == 2) begin
            total++; if (st_q[0] !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd68}) $display("FAIL b2b_status0 got %h want %h", st_q[0], {1'b1, 1'b1, 1'b0, 1'b0, 16'd68}); else passed++;
            total++; if (st_q[1] !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd72}) $display("FAIL b2b_status1 got %h want %h", st_q[1], {1'b1, 1'b1, 1'b0, 1'b0, 16'd72}); else passed++;
        end
        total++; if (out_q.size() !== 66) $display("FAIL b2b_out_count got %0d want 66", out_q.size()); else passed++;
        idx = first_out_mismatch();
        total++; if (idx != -1) $display("FAIL b2b_out_words at %0d got %h want %h", idx, out_q[idx], exp_q[idx]); else passed++;
    endtask

    task automatic test_giant();
        // 759 words is the largest legal frame; 760 is a giant.
        clear_capture();
        build_frame(757, 16'h1000, 1'b0);
        send_tx();
        exp_good++;
        total++; if (st_q.size() !== 1 || st_q[0][18:0] !== {1'b1, 1'b0, 1'b0, 16'd1518})
            $display("FAIL max759_status got n=%0d %h want n=1 %h", st_q.size(), (st_q.size() > 0) ? st_q[0][18:0] : 19'h0, {1'b1, 1'b0, 1'b0, 16'd1518}); else passed++;
        clear_capture();
        build_frame(758, 16'h2000, 1'b0);
        send_tx();
        exp_bad++;
        total++; if (st_q.size() !== 1 || st_q[0][18:0] !== {1'b1, 1'b0, 1'b1, 16'd1520})
            $display("FAIL giant760_status got n=%0d %h want n=1 %h", st_q.size(), (st_q.size() > 0) ? st_q[0][18:0] : 19'h0, {1'b1, 1'b0, 1'b1, 16'd1520}); else passed++;
        total++; if (out_q.size() !== 758) $display("FAIL giant760_out_count got %0d want 758", out_q.size()); else passed++;
        total++; if (good_cnt !== (STATS ? 32'(exp_good) : 32'd0) || bad_cnt !== (STATS ? 32'(exp_bad) : 32'd0))
            $display("FAIL giant_counters got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, STATS ? exp_good : 0, STATS ? exp_bad : 0); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int lasts;
        int idx;
        clear_capture();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 16'h0500 + 16'(i); s_last = 1'b0;
        end
        // A word arriving with reset must be ignored.
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD; s_last = 1'b1;
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        repeat (4) @(negedge clk);
        exp_good = 0;
        exp_bad  = 0;
        lasts = 0;
        foreach (out_q[i]) if (out_q[i][16]) lasts++;
        total++; if (st_q.size() !== 0) $display("FAIL abort_st_count got %0d want 0", st_q.size()); else passed++;
        total++; if (lasts !== 0) $display("FAIL abort_m_last got %0d want 0", lasts); else passed++;
        total++; if ({good_cnt, bad_cnt} !== 64'h0) $display("FAIL abort_counters got %h want 0", {good_cnt, bad_cnt}); else passed++;
        clear_capture();
        build_frame(30, 16'h0000, 1'b0);
        send_tx();
        exp_good++;
        total++; if (st_q.size() !== 1 || st_q[0] !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd64})
            $display("FAIL post_abort_status got n=%0d %h want n=1 %h", st_q.size(), (st_q.size() > 0) ? st_q[0] : 20'h0, {1'b1, 1'b1, 1'b0, 1'b0, 16'd64}); else passed++;
        idx = first_out_mismatch();
        total++; if (out_q.size() !== 30 || idx != -1) $display("FAIL post_abort_out got n=%0d mismatch_at=%0d want n=30 mismatch_at=-1", out_q.size(), idx); else passed++;
        total++; if (good_cnt !== (STATS ? 32'(exp_good) : 32'd0) || bad_cnt !== (STATS ? 32'(exp_bad) : 32'd0))
            $display("FAIL post_abort_counters got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, STATS ? exp_good : 0, STATS ? exp_bad : 0); else passed++;
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_bad_fcs();
        test_min_frame();
        test_back_to_back();
        test_giant();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
